// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiter.
// Default bus widths match the 64Kx16 RAM slave.
package wb_arb_pkg;

    localparam int ADR_W_DEF = 16;
    localparam int DAT_W_DEF = 16;
    localparam int MAX_NM    = 8;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Nearest requester after `last`, wrapping; returns `last` when nothing is requested.
    // Fixed 8-step scan keeps the loop static; steps beyond nm are masked off.
    function automatic logic [2:0] rr_pick(input logic [MAX_NM-1:0] req,
                                           input logic [2:0]        last,
                                           input int                nm);
        logic [2:0] pick;
        int         idx;
        pick = last;
        for (int k = MAX_NM; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= nm) idx = idx - nm;
            if (k <= nm && req[idx[2:0]]) pick = idx[2:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Bus bundle between NM Wishbone masters, the arbiter and the single shared slave.
// The arbiter uses the `arbiter` view; masters and the slave use their own modports.
interface wb_arbiter_rr_if
    import wb_arb_pkg::*;
#(
    parameter int NM    = 4,
    parameter int ADR_W = ADR_W_DEF,
    parameter int DAT_W = DAT_W_DEF
);

    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_we;
    logic [ADR_W-1:0] m_adr   [NM];
    logic [DAT_W-1:0] m_dat_i [NM];
    logic [DAT_W-1:0] m_dat_o;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;

    logic             s_cyc;
    logic             s_stb;
    logic             s_we;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_o;
    logic [DAT_W-1:0] s_dat_i;
    logic             s_ack;

    modport arbiter (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_i, s_dat_i, s_ack,
        output m_dat_o, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_o
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_i,
        input  m_dat_o, m_ack, m_err
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_dat_o,
        output s_dat_i, s_ack
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin priority encoder: first requester after `last`, wrapping.
// `any` flags that at least one request is present.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM    = 4,
    parameter int IDX_W = $clog2(NM)
) (
    input  logic [NM-1:0]    req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt,
    output logic             any
);

    logic [MAX_NM-1:0] req_ext;
    logic [2:0]        last_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[NM-1:0]    = req;
        last_ext           = '0;
        last_ext[IDX_W-1:0] = last;
        gnt                = IDX_W'(rr_pick(req_ext, last_ext, NM));
        any                = |req;
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone classic slave among NM masters.
// Grant is held for the whole bus cycle; a watchdog ends stalled strobes with m_err.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NM      = 4,
    parameter int ADR_W   = ADR_W_DEF,
    parameter int DAT_W   = DAT_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_arbiter_rr_if.arbiter bus
);

    localparam int IDX_W = $clog2(NM);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NM - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] last;
    logic [WD_W-1:0]  wd_cnt;

    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic             cur_stb;
    logic             wd_fire;

    wb_rr_pick #(.NM(NM), .IDX_W(IDX_W)) u_pick (
        .req  (bus.m_cyc),
        .last (last),
        .gnt  (pick),
        .any  (any_req)
    );

    assign cur_stb = bus.m_stb[gnt];
    assign wd_fire = (TIMEOUT > 0) && (state == BUSY) && (wd_cnt == WD_LAST)
                     && cur_stb && !bus.s_ack;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            last   <= IDX_LAST;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (any_req) begin
                        gnt   <= pick;
                        last  <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.m_cyc[gnt]) begin
                        state  <= IDLE;
                        wd_cnt <= '0;
                    end else if (bus.s_ack || !cur_stb || wd_fire || TIMEOUT == 0) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the BUSY override, so no latch
    // is inferred for the paths not taken.
    always_comb begin
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = '0;
        bus.s_dat_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        if (state == BUSY) begin
            bus.s_cyc      = bus.m_cyc[gnt];
            bus.s_stb      = cur_stb & ~wd_fire;
            bus.s_we       = bus.m_we[gnt];
            bus.s_adr      = bus.m_adr[gnt];
            bus.s_dat_o    = bus.m_dat_i[gnt];
            bus.m_dat_o    = bus.s_dat_i;
            bus.m_ack[gnt] = bus.s_ack & bus.m_cyc[gnt];
            bus.m_err[gnt] = wd_fire;
        end
    end

endmodule
